conv_encoder: RTL and testbench

CONV_ENCODER -- requirements
Module: conv_encoder

---
 rtl/viterbi_pkg.sv | 35 +++
 rtl/conv_enc_core.sv | 48 ++++
 rtl/conv_encoder.sv | 158 +++++++++++++++
 tb/tb_conv_encoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// ============================================================================
//  Module   : viterbi_pkg
//  Brief    : Shared code constants, generator polynomials and encoder FSM
//             state encoding for the convolutional encoder / Viterbi pair.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package viterbi_pkg;

    // Constraint length, trellis size and number of zero tail bits
    localparam int K          = 4;
    localparam int NUM_STATES = 8;
    localparam int TAIL_LEN   = 3;

    // Generator taps, MSB applies to the incoming bit, LSB to the oldest bit
    localparam logic [3:0] G0 = 4'b1111;
    localparam logic [3:0] G1 = 4'b1101;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENCODE     = 2'd1,
        TAIL       = 2'd2,
        FLUSH_DONE = 2'd3
    } enc_state_t;

    // Parity of the generator taps over {d, sr[0], sr[1], sr[2]}
    function automatic logic gen_bit(input logic [3:0] g, input logic d,
                                     input logic [2:0] sr);
        gen_bit = ^(g & {d, sr[0], sr[1], sr[2]});
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_enc_core.sv
// ============================================================================
//  Module   : conv_enc_core
//  Brief    : K=4 shift register and G0/G1 parity generators. Outputs are
//             combinational from the current bit and register contents.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_enc_core
    import viterbi_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic shift_en_i,
    input  logic d_i,
    output logic c1_o,
    output logic c0_o
);

    logic [K-2:0] sr_q;
    logic [K-2:0] sr_d;

    // Next register contents: clear at frame start, shift newest bit into sr[0]
    always_comb begin
        sr_d = sr_q;
        if (clear_i) begin
            sr_d = '0;
        end else if (shift_en_i) begin
            sr_d = {sr_q[K-3:0], d_i};
        end
    end

    // Shift register storage
    always_ff @(posedge clock) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign c1_o = gen_bit(G0, d_i, sr_q);
    assign c0_o = gen_bit(G1, d_i, sr_q);

endmodule

`default_nettype wire

// File: rtl/conv_encoder.sv
// ============================================================================
//  Module   : conv_encoder
//  Brief    : Framed rate-1/2 K=4 convolutional encoder. Each accepted bit
//             produces a registered symbol held SYM_PERIOD cycles; a frame is
//             closed by three zero tail symbols and a one-cycle done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_encoder
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN  = 20,
    parameter int SYM_PERIOD = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [1:0] Rx,
    output logic       rx_valid,
    output logic       seqrdy,
    output logic       done
);

    localparam int C_BIT_W  = $clog2(FRAME_LEN + 1);
    localparam int C_SLOT_W = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;

    localparam logic [C_BIT_W-1:0]  C_BIT_LAST  = C_BIT_W'(FRAME_LEN);
    localparam logic [C_SLOT_W-1:0] C_SLOT_LAST = C_SLOT_W'(SYM_PERIOD - 1);
    localparam logic [1:0]          C_TAIL_LAST = 2'(TAIL_LEN);

    enc_state_t            state_q,    state_d;
    logic [C_BIT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [C_SLOT_W-1:0]   slot_q,     slot_d;
    logic [1:0]            tail_cnt_q, tail_cnt_d;
    logic [1:0]            rx_q,       rx_d;
    logic                  rx_valid_q, rx_valid_d;

    logic ready_w;
    logic emit_w;
    logic core_d_w;
    logic core_clear_w;
    logic c1_w;
    logic c0_w;

    conv_enc_core u_core (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (core_clear_w),
        .shift_en_i (emit_w),
        .d_i        (core_d_w),
        .c1_o       (c1_w),
        .c0_o       (c0_w)
    );

    // Next-state, counters and symbol register inputs. A slot period begins
    // with an emitted symbol at slot 0 and ends at slot SYM_PERIOD-1; a slot
    // 0 without an emitted symbol is a stall and holds everything.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        slot_d       = slot_q;
        tail_cnt_d   = tail_cnt_q;
        rx_d         = rx_q;
        rx_valid_d   = 1'b0;
        ready_w      = (state_q == ENCODE) && (slot_q == '0);
        emit_w       = 1'b0;
        core_d_w     = 1'b0;
        core_clear_w = 1'b0;

        case (state_q)
            IDLE: begin
                rx_d = '0;
                if (start) begin
                    state_d      = ENCODE;
                    bit_cnt_d    = '0;
                    slot_d       = '0;
                    tail_cnt_d   = '0;
                    core_clear_w = 1'b1;
                end
            end
            ENCODE: begin
                core_d_w = din;
                emit_w   = ready_w && din_valid;
                if (emit_w) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (emit_w || (slot_q != '0)) begin
                    if (slot_q == C_SLOT_LAST) begin
                        slot_d = '0;
                        if (bit_cnt_d == C_BIT_LAST) begin
                            state_d = TAIL;
                        end
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
            end
            TAIL: begin
                emit_w = (slot_q == '0);
                if (emit_w) begin
                    tail_cnt_d = tail_cnt_q + 1'b1;
                end
                if (slot_q == C_SLOT_LAST) begin
                    slot_d = '0;
                    if (tail_cnt_d == C_TAIL_LAST) begin
                        state_d = FLUSH_DONE;
                    end
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            FLUSH_DONE: begin
                rx_d    = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (emit_w) begin
            rx_d       = {c1_w, c0_w};
            rx_valid_d = 1'b1;
        end
    end

    // State, counter and output symbol registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            slot_q     <= '0;
            tail_cnt_q <= '0;
            rx_q       <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            slot_q     <= slot_d;
            tail_cnt_q <= tail_cnt_d;
            rx_q       <= rx_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign din_ready = ready_w;
    assign Rx        = rx_q;
    assign rx_valid  = rx_valid_q;
    assign seqrdy    = (state_q == ENCODE) || (state_q == TAIL);
    assign done      = (state_q == FLUSH_DONE);

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder.sv
// ============================================================================
//  Module   : tb_conv_encoder
//  Brief    : Self-checking bench for conv_encoder; one instance with
//             SYM_PERIOD=3 and one with SYM_PERIOD=1, both FRAME_LEN=20.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_encoder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       start_a = 1'b0, din_a = 1'b0, din_valid_a = 1'b0;
    logic       start_b = 1'b0, din_b = 1'b0, din_valid_b = 1'b0;
    logic       rdy_a, rxv_a, seq_a, done_a;
    logic       rdy_b, rxv_b, seq_b, done_b;
    logic [1:0] rx_a, rx_b;

    int         n_tests = 0;
    int         n_fail  = 0;

    logic [1:0] exp_q[$];
    logic [1:0] got_syms[32];
    int         got_n;

    logic [1:0] s_rx;
    logic       s_rxv, s_seq, s_done, s_rdy;

    always #5 clock = ~clock;

    conv_encoder #(.FRAME_LEN(20), .SYM_PERIOD(3)) dut_a (
        .clock     (clock),
        .reset     (reset),
        .start     (start_a),
        .din       (din_a),
        .din_valid (din_valid_a),
        .din_ready (rdy_a),
        .Rx        (rx_a),
        .rx_valid  (rxv_a),
        .seqrdy    (seq_a),
        .done      (done_a)
    );

    conv_encoder #(.FRAME_LEN(20), .SYM_PERIOD(1)) dut_b (
        .clock     (clock),
        .reset     (reset),
        .start     (start_b),
        .din       (din_b),
        .din_valid (din_valid_b),
        .din_ready (rdy_b),
        .Rx        (rx_b),
        .rx_valid  (rxv_b),
        .seqrdy    (seq_b),
        .done      (done_b)
    );

    task automatic sample(input bit sel);
        if (sel) begin
            s_rx = rx_b; s_rxv = rxv_b; s_seq = seq_b; s_done = done_b; s_rdy = rdy_b;
        end else begin
            s_rx = rx_a; s_rxv = rxv_a; s_seq = seq_a; s_done = done_a; s_rdy = rdy_a;
        end
    endtask

    task automatic drive(input bit sel, input logic st, input logic d, input logic v);
        if (sel) begin
            start_b = st; din_b = d; din_valid_b = v;
        end else begin
            start_a = st; din_a = d; din_valid_a = v;
        end
    endtask

    // Runs one complete frame: reference encoder pushes expected symbols on
    // each handshake, symbols are popped and compared when rx_valid pulses.
    task automatic run_frame(input bit sel, input logic [19:0] bits, input int stall_at,
                             input int stall_len, input bit poke, input int exp_seq);
        logic [2:0] msr;
        logic [1:0] e;
        logic [1:0] last_rx;
        logic       v;
        logic       d;
        int         idx, stall_left, seq_cnt, sym_cnt;
        bit         fin;
        msr = '0; idx = 0; stall_left = stall_len; seq_cnt = 0; sym_cnt = 0;
        last_rx = '0; fin = 1'b0; got_n = 0;
        exp_q.delete();
        @(negedge clock);
        drive(sel, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clock);
            sample(sel);
            n_tests++;
            if (s_rxv) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sym_extra: got Rx=%b with no symbol expected", s_rx);
                end else begin
                    e = exp_q.pop_front();
                    if (s_rx !== e) begin
                        n_fail++;
                        $display("FAIL symbol %0d: got %b expected %b", sym_cnt, s_rx, e);
                    end
                end
                if (got_n < 32) begin
                    got_syms[got_n] = s_rx;
                    got_n++;
                end
                sym_cnt++;
                last_rx = s_rx;
            end else if (s_rx !== last_rx) begin
                n_fail++;
                $display("FAIL rx_hold cycle %0d: got %b expected %b", c, s_rx, last_rx);
            end
            if (s_seq) seq_cnt++;
            if (s_done) fin = 1'b1;
            v = 1'b0;
            d = 1'b0;
            if (idx < 20 && !fin) begin
                d = bits[idx];
                if (s_rdy && idx == stall_at && stall_left > 0) stall_left--;
                else v = 1'b1;
            end
            drive(sel, poke && !fin && (c == 10 || c == 65), d, v);
            if (s_rdy && v) begin
                exp_q.push_back({d ^ msr[0] ^ msr[1] ^ msr[2], d ^ msr[0] ^ msr[2]});
                msr = {msr[1:0], d};
                idx++;
                if (idx == 20) begin
                    for (int t = 0; t < 3; t++) begin
                        exp_q.push_back({msr[0] ^ msr[1] ^ msr[2], msr[0] ^ msr[2]});
                        msr = {msr[1:0], 1'b0};
                    end
                end
            end
        end
        n_tests++;
        if (!fin) begin
            n_fail++;
            $display("FAIL frame_timeout: done not seen, got 0 expected 1");
        end
        n_tests++;
        if (sym_cnt != 23) begin
            n_fail++;
            $display("FAIL symbol_count: got %0d expected 23", sym_cnt);
        end
        n_tests++;
        if (seq_cnt != exp_seq) begin
            n_fail++;
            $display("FAIL seqrdy_cycles: got %0d expected %0d", seq_cnt, exp_seq);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_symbols: got %0d expected 0", exp_q.size());
        end
        drive(sel, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            sample(sel);
            n_tests++;
            if ({s_rx, s_rxv, s_seq, s_done, s_rdy} !== 6'b0) begin
                n_fail++;
                $display("FAIL idle_after_done: got Rx=%b rxv=%b seq=%b done=%b rdy=%b expected all 0",
                         s_rx, s_rxv, s_seq, s_done, s_rdy);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        sample(1'b0);
        n_tests++;
        if ({s_rx, s_rxv, s_seq, s_done, s_rdy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_a: got Rx=%b rxv=%b seq=%b done=%b rdy=%b expected all 0",
                     s_rx, s_rxv, s_seq, s_done, s_rdy);
        end
        sample(1'b1);
        n_tests++;
        if ({s_rx, s_rxv, s_seq, s_done, s_rdy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_b: got Rx=%b rxv=%b seq=%b done=%b rdy=%b expected all 0",
                     s_rx, s_rxv, s_seq, s_done, s_rdy);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_all_zero();
        run_frame(1'b0, 20'h0, -1, 0, 1'b0, 69);
    endtask

    task automatic test_impulse();
        logic [1:0] imp[4];
        logic [1:0] e;
        imp[0] = 2'b11; imp[1] = 2'b11; imp[2] = 2'b10; imp[3] = 2'b11;
        run_frame(1'b0, 20'h00001, -1, 0, 1'b0, 69);
        for (int i = 0; i < 23; i++) begin
            e = (i < 4) ? imp[i] : 2'b00;
            n_tests++;
            if (i >= got_n || got_syms[i] !== e) begin
                n_fail++;
                $display("FAIL impulse_sym %0d: got %b expected %b", i, got_syms[i], e);
            end
        end
    endtask

    task automatic test_stall();
        run_frame(1'b0, 20'hB52C7, 8, 5, 1'b0, 74);
    endtask

    task automatic test_mid_reset();
        logic [19:0] bits;
        int          idx;
        bits = 20'hFFFFF;
        idx  = 0;
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 100 && idx < 7; c++) begin
            @(negedge clock);
            sample(1'b0);
            drive(1'b0, 1'b0, bits[idx], 1'b1);
            if (s_rdy) idx++;
        end
        @(negedge clock);
        n_tests++;
        if (idx != 7) begin
            n_fail++;
            $display("FAIL mid_reset_setup: got %0d bits expected 7", idx);
        end
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clock);
        sample(1'b0);
        n_tests++;
        if ({s_rx, s_rxv, s_seq, s_done, s_rdy} !== 6'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got Rx=%b rxv=%b seq=%b done=%b rdy=%b expected all 0",
                     s_rx, s_rxv, s_seq, s_done, s_rdy);
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        sample(1'b0);
        n_tests++;
        if ({s_seq, s_done, s_rdy} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_priority: got seq=%b done=%b rdy=%b expected all 0",
                     s_seq, s_done, s_rdy);
        end
        test_impulse();
    endtask

    task automatic test_start_ignored();
        run_frame(1'b0, 20'h5A3C1, -1, 0, 1'b1, 69);
    endtask

    task automatic test_back_to_back();
        logic [19:0] bits;
        bits = 20'($urandom);
        run_frame(1'b1, bits, -1, 0, 1'b0, 23);
        bits = 20'($urandom);
        run_frame(1'b1, bits, -1, 0, 1'b0, 23);
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_impulse();
        test_stall();
        test_mid_reset();
        test_start_ignored();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
